// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter multiplexing NCH read channels and one write port onto a
// single SDRAM request channel, with overflow and timeout error reporting.
module sdram_port_arbiter #(
    parameter int NCH     = 4,
    parameter int AW      = 24,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*AW-1:0] ch_addr,
    output logic [NCH-1:0]    ch_rdy,
    output logic [15:0]       ch_dout,
    input  logic              wr_req,
    input  logic [AW-1:0]     wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [1:0]        wr_be,
    output logic              wr_rdy,
    input  logic              rd_hold,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_be,
    output logic              mem_rnw,
    input  logic              mem_rdy,
    input  logic [15:0]       mem_dout,
    output logic              err_timeout,
    output logic              err_ovf
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = 10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  pending_q, pending_d;
    logic [NCH-1:0]  load_rd, clr_rd, ch_rdy_d;
    logic            wr_pend_q, wr_pend_d;
    logic            load_wr, clr_wr, ovf;
    logic [AW-1:0]   addr_q [NCH];
    logic [AW-1:0]   wr_addr_q;
    logic [15:0]     wr_data_q;
    logic [1:0]      wr_be_q;
    logic [IW-1:0]   rr_ptr_q, gnt_idx_q, rd_sel;
    logic            gnt_wr_q;
    logic            rd_found, grant_wr, grant_rd, done, abort;
    logic [CW-1:0]   cnt_q;
    logic [IW:0]     cand;

    logic            mem_req_q, mem_rnw_q;
    logic [AW-1:0]   mem_addr_q;
    logic [15:0]     mem_din_q, ch_dout_q;
    logic [1:0]      mem_be_q;
    logic [NCH-1:0]  ch_rdy_q;
    logic            wr_rdy_q, err_timeout_q, err_ovf_q;

    // Round-robin search starting one past the last completed read channel.
    always_comb begin
        rd_found = 1'b0;
        rd_sel   = '0;
        cand     = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NCH)) cand = cand - (IW+1)'(NCH);
            if (!rd_found && pending_q[cand[IW-1:0]]) begin
                rd_found = 1'b1;
                rd_sel   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_pend_q) begin
                    grant_wr = 1'b1;
                    state_d  = S_ISSUE;
                end else if (!rd_hold && rd_found) begin
                    grant_rd = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_rdy) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A request landing in the same cycle its slot is freed is kept, not flagged.
    always_comb begin
        clr_rd = '0;
        if ((done || abort) && !gnt_wr_q) clr_rd[gnt_idx_q] = 1'b1;
        clr_wr    = (done || abort) && gnt_wr_q;
        load_rd   = ch_req & (~pending_q | clr_rd);
        pending_d = (pending_q & ~clr_rd) | load_rd;
        load_wr   = wr_req && (!wr_pend_q || clr_wr);
        wr_pend_d = (wr_pend_q && !clr_wr) || load_wr;
        ovf       = (|(ch_req & ~load_rd)) || (wr_req && !load_wr);
        ch_rdy_d  = done ? clr_rd : '0;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            wr_pend_q     <= 1'b0;
            rr_ptr_q      <= IW'(NCH - 1);
            gnt_idx_q     <= '0;
            gnt_wr_q      <= 1'b0;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_rnw_q     <= 1'b1;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_be_q      <= '0;
            ch_rdy_q      <= '0;
            wr_rdy_q      <= 1'b0;
            ch_dout_q     <= '0;
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            wr_pend_q     <= wr_pend_d;
            mem_req_q     <= grant_wr || grant_rd;
            cnt_q         <= (state_q == S_WAIT && state_d == S_WAIT) ? cnt_q + 1'b1 : '0;
            ch_rdy_q      <= ch_rdy_d;
            wr_rdy_q      <= done && gnt_wr_q;
            err_timeout_q <= err_timeout_q || abort;
            err_ovf_q     <= err_ovf_q || ovf;
            if (grant_wr) begin
                gnt_wr_q   <= 1'b1;
                mem_addr_q <= wr_addr_q;
                mem_din_q  <= wr_data_q;
                mem_be_q   <= wr_be_q;
                mem_rnw_q  <= 1'b0;
            end else if (grant_rd) begin
                gnt_wr_q   <= 1'b0;
                gnt_idx_q  <= rd_sel;
                mem_addr_q <= addr_q[rd_sel];
                mem_din_q  <= '0;
                mem_be_q   <= 2'b11;
                mem_rnw_q  <= 1'b1;
            end
            if (done && !gnt_wr_q) begin
                ch_dout_q <= mem_dout;
                rr_ptr_q  <= gnt_idx_q;
            end
        end
    end

    // Request payloads are plain storage, qualified by the pending flags.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (load_rd[i]) addr_q[i] <= ch_addr[i*AW +: AW];
        end
        if (load_wr) begin
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
            wr_be_q   <= wr_be;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_be      = mem_be_q;
    assign mem_rnw     = mem_rnw_q;
    assign ch_rdy      = ch_rdy_q;
    assign wr_rdy      = wr_rdy_q;
    assign ch_dout     = ch_dout_q;
    assign err_timeout = err_timeout_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scenario bench for sdram_port_arbiter: expected issues and completions are
// queued as stimulus is applied and popped when the DUT produces them.
module tb_sdram_port_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 24;
    localparam int TO  = 64;

    logic              clk = 1'b0;
    logic              RSTn;
    logic [NCH-1:0]    ch_req;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_rdy;
    logic [15:0]       ch_dout;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [15:0]       wr_data;
    logic [1:0]        wr_be;
    logic              wr_rdy;
    logic              rd_hold;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic [15:0]       mem_din;
    logic [1:0]        mem_be;
    logic              mem_rnw;
    logic              mem_rdy;
    logic [15:0]       mem_dout;
    logic              err_timeout;
    logic              err_ovf;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic          exp_rnw_q[$];
    logic [1:0]    exp_be_q[$];
    logic [4:0]    exp_rdy_q[$];
    logic [15:0]   exp_dout_q[$];

    localparam logic [66:0] RESET_VEC = {1'b0, 1'b1, 24'h0, 16'h0, 2'b00, 4'b0000, 1'b0, 16'h0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    sdram_port_arbiter #(.NCH(NCH), .AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .RSTn(RSTn),
        .ch_req(ch_req), .ch_addr(ch_addr), .ch_rdy(ch_rdy), .ch_dout(ch_dout),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_rdy(wr_rdy),
        .rd_hold(rd_hold),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be), .mem_rnw(mem_rnw),
        .mem_rdy(mem_rdy), .mem_dout(mem_dout),
        .err_timeout(err_timeout), .err_ovf(err_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic respond(input int d, input logic [15:0] dout);
        repeat (d) tick();
        mem_rdy  = 1'b1;
        mem_dout = dout;
        tick();
        mem_rdy  = 1'b0;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        tick();
        tick();
        RSTn = 1'b1;
        tick();
    endtask

    task automatic set_addr(input int ch, input logic [AW-1:0] a);
        ch_addr[ch*AW +: AW] = a;
    endtask

    task automatic push_iss(input logic [AW-1:0] a, input logic rnw, input logic [1:0] be);
        exp_addr_q.push_back(a);
        exp_rnw_q.push_back(rnw);
        exp_be_q.push_back(be);
    endtask

    task automatic push_rdy(input logic [4:0] r, input logic [15:0] d);
        exp_rdy_q.push_back(r);
        exp_dout_q.push_back(d);
    endtask

    task automatic test_reset();
        logic [66:0] got;
        RSTn = 1'b0;
        tick();
        tick();
        got = {mem_req, mem_rnw, mem_addr, mem_din, mem_be, ch_rdy, wr_rdy, ch_dout, err_timeout, err_ovf};
        checks++;
        if (got !== RESET_VEC) begin
            failures++;
            $display("FAIL reset_values got %h want %h", got, RESET_VEC);
        end
        RSTn = 1'b1;
        tick();
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        tick();
        checks++;
        if ({mem_req, wr_rdy, ch_rdy} !== 6'b0) begin
            failures++;
            $display("FAIL idle_mem_rdy got req/wr/ch %b/%b/%b want 0/0/0000", mem_req, wr_rdy, ch_rdy);
        end
    endtask

    task automatic test_single_read();
        logic [AW-1:0] ea;
        logic          er;
        logic [1:0]    eb;
        logic [4:0]    rr;
        logic [15:0]   ed;
        push_iss(24'h000123, 1'b1, 2'b11);
        push_rdy(5'b00010, 16'hBEEF);
        set_addr(1, 24'h000123);
        ch_req = 4'b0010;
        tick();
        ch_req = '0;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL single_cycle1_req got %b want 0", mem_req);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL single_cycle2_req got %b want 1", mem_req);
        end
        ea = exp_addr_q.pop_front(); er = exp_rnw_q.pop_front(); eb = exp_be_q.pop_front();
        checks++;
        if ({mem_addr, mem_rnw, mem_be} !== {ea, er, eb}) begin
            failures++;
            $display("FAIL single_issue got %h/%b/%b want %h/%b/%b", mem_addr, mem_rnw, mem_be, ea, er, eb);
        end
        tick();
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL single_req_width got %b want 0", mem_req);
        end
        repeat (4) tick();
        checks++;
        if ({ch_rdy, mem_addr, mem_rnw} !== {4'b0000, ea, 1'b1}) begin
            failures++;
            $display("FAIL single_wait_hold got rdy %b addr %h rnw %b want 0000 %h 1", ch_rdy, mem_addr, mem_rnw, ea);
        end
        mem_rdy  = 1'b1;
        mem_dout = 16'hBEEF;
        tick();
        mem_rdy = 1'b0;
        rr = exp_rdy_q.pop_front(); ed = exp_dout_q.pop_front();
        checks++;
        if ({wr_rdy, ch_rdy, ch_dout} !== {rr, ed}) begin
            failures++;
            $display("FAIL single_done got %b/%b/%h want %b/%h", wr_rdy, ch_rdy, ch_dout, rr, ed);
        end
        tick();
        checks++;
        if (ch_rdy !== 4'b0000) begin
            failures++;
            $display("FAIL single_rdy_pulse got %b want 0000", ch_rdy);
        end
    endtask

    task automatic test_round_robin();
        bit            ok;
        logic [AW-1:0] ea;
        logic          er;
        logic [1:0]    eb;
        logic [4:0]    rr;
        logic [15:0]   ed;
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            set_addr(i, 24'h000100 + AW'(i));
            push_iss(24'h000100 + AW'(i), 1'b1, 2'b11);
            push_rdy({1'b0, 4'(1 << i)}, 16'hA000 + 16'(i));
        end
        push_iss(24'h000200, 1'b1, 2'b11);
        push_rdy(5'b00001, 16'hA004);
        ch_req = 4'hF;
        tick();
        ch_req = '0;
        for (int n = 0; n < 5; n++) begin
            wait_req(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rr_wait%0d got no mem_req want mem_req", n);
                return;
            end
            ea = exp_addr_q.pop_front(); er = exp_rnw_q.pop_front(); eb = exp_be_q.pop_front();
            checks++;
            if ({mem_addr, mem_rnw, mem_be} !== {ea, er, eb}) begin
                failures++;
                $display("FAIL rr_issue%0d got %h/%b/%b want %h/%b/%b", n, mem_addr, mem_rnw, mem_be, ea, er, eb);
            end
            respond(1 + (n % 3), 16'hA000 + 16'(n));
            rr = exp_rdy_q.pop_front(); ed = exp_dout_q.pop_front();
            checks++;
            if ({wr_rdy, ch_rdy, ch_dout} !== {rr, ed}) begin
                failures++;
                $display("FAIL rr_done%0d got %b/%b/%h want %b/%h", n, wr_rdy, ch_rdy, ch_dout, rr, ed);
            end
            if (n == 0) begin
                set_addr(0, 24'h000200);
                ch_req = 4'b0001;
                tick();
                ch_req = '0;
            end
        end
    endtask

    task automatic test_write_hold();
        bit            ok;
        int            seen;
        logic [AW-1:0] ea;
        logic          er;
        logic [1:0]    eb;
        logic [4:0]    rr;
        logic [15:0]   ed;
        do_reset();
        rd_hold = 1'b1;
        wr_addr = 24'h00ABCD;
        wr_data = 16'h1234;
        wr_be   = 2'b01;
        set_addr(2, 24'h000222);
        push_iss(24'h00ABCD, 1'b0, 2'b01);
        push_rdy(5'b10000, 16'h0000);
        wr_req = 1'b1;
        ch_req = 4'b0100;
        tick();
        wr_req = 1'b0;
        ch_req = '0;
        wait_req(ok);
        ea = exp_addr_q.pop_front(); er = exp_rnw_q.pop_front(); eb = exp_be_q.pop_front();
        checks++;
        if (!ok || {mem_addr, mem_rnw, mem_be, mem_din} !== {ea, er, eb, 16'h1234}) begin
            failures++;
            $display("FAIL wr_issue got ok=%0d %h/%b/%b/%h want %h/%b/%b/1234", ok, mem_addr, mem_rnw, mem_be, mem_din, ea, er, eb);
        end
        respond(2, 16'h5555);
        rr = exp_rdy_q.pop_front(); ed = exp_dout_q.pop_front();
        checks++;
        if ({wr_rdy, ch_rdy} !== rr) begin
            failures++;
            $display("FAIL wr_done got %b/%b want %b (data %h)", wr_rdy, ch_rdy, rr, ed);
        end
        seen = 0;
        repeat (12) begin
            tick();
            if (mem_req === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL hold_blocks_read got %0d mem_req want 0", seen);
        end
        push_iss(24'h000222, 1'b1, 2'b11);
        push_rdy(5'b00100, 16'h7777);
        rd_hold = 1'b0;
        wait_req(ok);
        ea = exp_addr_q.pop_front(); er = exp_rnw_q.pop_front(); eb = exp_be_q.pop_front();
        checks++;
        if (!ok || {mem_addr, mem_rnw, mem_be} !== {ea, er, eb}) begin
            failures++;
            $display("FAIL hold_release_issue got ok=%0d %h/%b/%b want %h/%b/%b", ok, mem_addr, mem_rnw, mem_be, ea, er, eb);
        end
        respond(1, 16'h7777);
        rr = exp_rdy_q.pop_front(); ed = exp_dout_q.pop_front();
        checks++;
        if ({wr_rdy, ch_rdy, ch_dout} !== {rr, ed}) begin
            failures++;
            $display("FAIL hold_release_done got %b/%b/%h want %b/%h", wr_rdy, ch_rdy, ch_dout, rr, ed);
        end
    endtask

    task automatic test_timeout();
        bit            ok, got2, rdy_seen, early;
        int            first_err;
        logic [AW-1:0] ea;
        logic          er;
        logic [1:0]    eb;
        logic [4:0]    rr;
        logic [15:0]   ed;
        do_reset();
        set_addr(0, 24'h000300);
        set_addr(1, 24'h000301);
        push_iss(24'h000300, 1'b1, 2'b11);
        push_iss(24'h000301, 1'b1, 2'b11);
        push_rdy(5'b00010, 16'h4242);
        ch_req = 4'b0011;
        tick();
        ch_req = '0;
        wait_req(ok);
        ea = exp_addr_q.pop_front(); er = exp_rnw_q.pop_front(); eb = exp_be_q.pop_front();
        checks++;
        if (!ok || mem_addr !== ea) begin
            failures++;
            $display("FAIL to_first_issue got ok=%0d addr %h want %h", ok, mem_addr, ea);
        end
        got2 = 1'b0; rdy_seen = 1'b0; early = 1'b0; first_err = -1;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (ch_rdy !== 4'b0000) rdy_seen = 1'b1;
            if (t == 32) early = err_timeout;
            if (err_timeout === 1'b1 && first_err < 0) first_err = t;
            if (mem_req === 1'b1) begin
                got2 = 1'b1;
                break;
            end
        end
        checks++;
        if (early !== 1'b0 || first_err < 60 || first_err > 70 || rdy_seen) begin
            failures++;
            $display("FAIL to_flag got early=%b first_err=%0d rdy_seen=%b want 0 60..70 0", early, first_err, rdy_seen);
        end
        ea = exp_addr_q.pop_front(); er = exp_rnw_q.pop_front(); eb = exp_be_q.pop_front();
        checks++;
        if (!got2 || {mem_addr, mem_rnw, mem_be} !== {ea, er, eb}) begin
            failures++;
            $display("FAIL to_next_issue got ok=%0d %h/%b/%b want %h/%b/%b", got2, mem_addr, mem_rnw, mem_be, ea, er, eb);
        end
        respond(1, 16'h4242);
        rr = exp_rdy_q.pop_front(); ed = exp_dout_q.pop_front();
        checks++;
        if ({wr_rdy, ch_rdy, ch_dout, err_timeout} !== {rr, ed, 1'b1}) begin
            failures++;
            $display("FAIL to_next_done got %b/%b/%h err=%b want %b/%h err=1", wr_rdy, ch_rdy, ch_dout, err_timeout, rr, ed);
        end
    endtask

    task automatic test_back_to_back();
        bit            ok;
        logic [AW-1:0] ea;
        logic          er;
        logic [1:0]    eb;
        logic [4:0]    rr;
        logic [15:0]   ed;
        do_reset();
        set_addr(0, 24'h000400);
        push_iss(24'h000400, 1'b1, 2'b11);
        push_iss(24'h000401, 1'b1, 2'b11);
        push_rdy(5'b00001, 16'h1111);
        push_rdy(5'b00001, 16'h2222);
        ch_req = 4'b0001;
        tick();
        ch_req = '0;
        wait_req(ok);
        ea = exp_addr_q.pop_front(); er = exp_rnw_q.pop_front(); eb = exp_be_q.pop_front();
        checks++;
        if (!ok || mem_addr !== ea) begin
            failures++;
            $display("FAIL b2b_first got ok=%0d addr %h want %h", ok, mem_addr, ea);
        end
        tick();
        mem_rdy  = 1'b1;
        mem_dout = 16'h1111;
        set_addr(0, 24'h000401);
        ch_req = 4'b0001;
        tick();
        mem_rdy = 1'b0;
        ch_req  = '0;
        rr = exp_rdy_q.pop_front(); ed = exp_dout_q.pop_front();
        checks++;
        if ({wr_rdy, ch_rdy, ch_dout} !== {rr, ed}) begin
            failures++;
            $display("FAIL b2b_first_done got %b/%b/%h want %b/%h", wr_rdy, ch_rdy, ch_dout, rr, ed);
        end
        wait_req(ok);
        ea = exp_addr_q.pop_front(); er = exp_rnw_q.pop_front(); eb = exp_be_q.pop_front();
        checks++;
        if (!ok || mem_addr !== ea || err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got ok=%0d addr %h ovf %b want %h ovf 0", ok, mem_addr, err_ovf, ea);
        end
        respond(2, 16'h2222);
        rr = exp_rdy_q.pop_front(); ed = exp_dout_q.pop_front();
        checks++;
        if ({wr_rdy, ch_rdy, ch_dout} !== {rr, ed}) begin
            failures++;
            $display("FAIL b2b_second_done got %b/%b/%h want %b/%h", wr_rdy, ch_rdy, ch_dout, rr, ed);
        end
    endtask

    task automatic test_overflow();
        bit            ok;
        int            seen;
        logic [AW-1:0] ea;
        logic          er;
        logic [1:0]    eb;
        logic [4:0]    rr;
        logic [15:0]   ed;
        do_reset();
        rd_hold = 1'b1;
        set_addr(0, 24'h000111);
        ch_req = 4'b0001;
        tick();
        ch_req = '0;
        tick();
        set_addr(0, 24'h000222);
        ch_req = 4'b0001;
        tick();
        ch_req = '0;
        checks++;
        if (err_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag got %b want 1", err_ovf);
        end
        push_iss(24'h000111, 1'b1, 2'b11);
        push_rdy(5'b00001, 16'h3333);
        rd_hold = 1'b0;
        wait_req(ok);
        ea = exp_addr_q.pop_front(); er = exp_rnw_q.pop_front(); eb = exp_be_q.pop_front();
        checks++;
        if (!ok || {mem_addr, mem_rnw, mem_be} !== {ea, er, eb}) begin
            failures++;
            $display("FAIL ovf_issue got ok=%0d %h/%b/%b want %h/%b/%b", ok, mem_addr, mem_rnw, mem_be, ea, er, eb);
        end
        respond(1, 16'h3333);
        rr = exp_rdy_q.pop_front(); ed = exp_dout_q.pop_front();
        checks++;
        if ({wr_rdy, ch_rdy, ch_dout} !== {rr, ed}) begin
            failures++;
            $display("FAIL ovf_done got %b/%b/%h want %b/%h", wr_rdy, ch_rdy, ch_dout, rr, ed);
        end
        seen = 0;
        repeat (20) begin
            tick();
            if (mem_req === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL ovf_single_req got %0d extra mem_req want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        bit          ok;
        int          bad;
        logic [66:0] got;
        do_reset();
        set_addr(3, 24'h5A5A5A);
        ch_req = 4'b1000;
        tick();
        ch_req = '0;
        wait_req(ok);
        tick();
        tick();
        checks++;
        if (!ok || mem_addr !== 24'h5A5A5A) begin
            failures++;
            $display("FAIL rstmid_issue got ok=%0d addr %h want 5a5a5a", ok, mem_addr);
        end
        #2;
        RSTn = 1'b0;
        #1;
        got = {mem_req, mem_rnw, mem_addr, mem_din, mem_be, ch_rdy, wr_rdy, ch_dout, err_timeout, err_ovf};
        checks++;
        if (got !== RESET_VEC) begin
            failures++;
            $display("FAIL rstmid_async got %h want %h", got, RESET_VEC);
        end
        tick();
        RSTn    = 1'b1;
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        bad = 0;
        repeat (6) begin
            if (ch_rdy !== 4'b0000 || mem_req !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rstmid_late_rdy got %0d cycles with ch_rdy/mem_req want 0", bad);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        RSTn     = 1'b0;
        ch_req   = '0;
        ch_addr  = '0;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_be    = '0;
        rd_hold  = 1'b0;
        mem_rdy  = 1'b0;
        mem_dout = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_hold();
        test_timeout();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
